ascon_aead128_packer: RTL and testbench

- Upstream input stage of the Ascon-AEAD128 core.
- Gathers a narrow byte stream of associated data (AD) and plaintext/ciphertext (DB) into 128-bit blocks.
- Applies Ascon 0x01/zero padding to the last block of each segment.
- Drives the core handshake: start, valid_ad, valid_db_in, with core ready as backpressure.
- Keeps start high through a session and drops it exactly when the final DB block is presented.

---
 rtl/ascon_aead128_packer_if.sv | 30 +++
 rtl/ascon_aead128_packer.sv | 181 ++++++++++++++++++
 tb/tb_ascon_aead128_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_aead128_packer_if.sv
// Byte-word input stream and 128-bit block output of the Ascon-AEAD128 input packer.
// master = packer side (consumes words, produces blocks); slave = producer/core side.
interface ascon_aead128_packer_if #(
  parameter int IN_BYTES = 4
);
  localparam int NBW = $clog2(IN_BYTES) + 1;

  logic [8*IN_BYTES-1:0] in_data;
  logic [NBW-1:0]        in_nbytes;
  logic                  in_type;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [127:0]          blk_data;
  logic [4:0]            blk_nbytes;
  logic                  blk_valid_ad;
  logic                  blk_valid_db;
  logic                  blk_start;
  logic                  blk_ready;

  modport master (
    input  in_data, in_nbytes, in_type, in_last, in_valid, blk_ready,
    output in_ready, blk_data, blk_nbytes, blk_valid_ad, blk_valid_db, blk_start
  );

  modport slave (
    output in_data, in_nbytes, in_type, in_last, in_valid, blk_ready,
    input  in_ready, blk_data, blk_nbytes, blk_valid_ad, blk_valid_db, blk_start
  );
endinterface

// File: rtl/ascon_aead128_packer.sv
// Packs AD/DB byte words into 0x01-padded 128-bit Ascon-AEAD128 blocks and drives the core handshake.
// Optional: define ASCON_PACKER_DBUF_EN to add an output block buffer so input keeps flowing during HOLD.
module ascon_aead128_packer #(
  parameter int IN_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ascon_aead128_packer_if.master bus,
  output logic                   err
);
  localparam int NBW = $clog2(IN_BYTES) + 1;
  localparam logic [NBW-1:0] FULL_NB = NBW'(IN_BYTES);

  typedef enum logic [2:0] {
    IDLE, COLLECT_AD, COLLECT_DB, HOLD_AD, HOLD_DB, PAD_AD, PAD_DB
  } state_t;

  state_t       state_q, state_d, base_state;
  logic [127:0] buf_q, buf_d, base_buf, word_ext;
  logic [4:0]   fill_q, fill_d, base_fill, new_fill;
  logic         final_q, final_d, pad_q, pad_d;
  logic         session_q, session_d, err_q, err_d;
  logic         coll_valid, coll_db, coll_pad, coll_final;
  logic [127:0] coll_data;
  logic [4:0]   coll_nbytes;
  logic         adv, accept, bad, seg_db;
  logic         pres_valid, pres_db, pres_final;
  logic [127:0] pres_data;
  logic [4:0]   pres_nbytes;

  // The collector buffer presents itself in HOLD/PAD; fill_q is the real byte count.
  always_comb begin
    coll_valid  = state_q inside {HOLD_AD, HOLD_DB, PAD_AD, PAD_DB};
    coll_db     = state_q inside {HOLD_DB, PAD_DB};
    coll_pad    = state_q inside {PAD_AD, PAD_DB};
    coll_final  = coll_pad || (final_q && !pad_q);
    coll_data   = coll_pad ? 128'h1 : buf_q;
    coll_nbytes = coll_pad ? 5'd0 : fill_q;
  end

`ifdef ASCON_PACKER_DBUF_EN
  logic         o_valid_q, o_db_q, o_final_q;
  logic [127:0] o_data_q;
  logic [4:0]   o_nbytes_q;

  // The collector block leaves HOLD/PAD whenever the output buffer is free:
  // either the core takes it directly or it is parked in the output buffer.
  assign adv = !o_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q  <= 1'b0;
      o_db_q     <= 1'b0;
      o_final_q  <= 1'b0;
      o_data_q   <= '0;
      o_nbytes_q <= '0;
    end else if (o_valid_q && bus.blk_ready) begin
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_nbytes_q <= '0;
    end else if (!o_valid_q && coll_valid && !bus.blk_ready) begin
      o_valid_q  <= 1'b1;
      o_db_q     <= coll_db;
      o_final_q  <= coll_final;
      o_data_q   <= coll_data;
      o_nbytes_q <= coll_nbytes;
    end
  end

  always_comb begin
    pres_valid  = o_valid_q || coll_valid;
    pres_db     = o_valid_q ? o_db_q     : coll_db;
    pres_final  = o_valid_q ? o_final_q  : coll_final;
    pres_data   = o_valid_q ? o_data_q   : coll_data;
    pres_nbytes = o_valid_q ? o_nbytes_q : coll_nbytes;
  end

  // A new session waits until the previous final block has left the output buffer.
  assign bus.in_ready = ((state_q == IDLE) && !o_valid_q) ||
                        (state_q inside {COLLECT_AD, COLLECT_DB}) ||
                        (coll_valid && adv && (base_state inside {COLLECT_AD, COLLECT_DB}));
`else
  assign adv         = bus.blk_ready;
  assign pres_valid  = coll_valid;
  assign pres_db     = coll_db;
  assign pres_final  = coll_final;
  assign pres_data   = coll_data;
  assign pres_nbytes = coll_nbytes;
  assign bus.in_ready = state_q inside {IDLE, COLLECT_AD, COLLECT_DB};
`endif

  // First retire the presented block (base_*), then merge any accepted word on top of it.
  always_comb begin
    base_state = state_q;
    base_buf   = buf_q;
    base_fill  = fill_q;
    final_d    = final_q;
    pad_d      = pad_q;
    session_d  = session_q;
    err_d      = err_q;

    if (coll_valid && adv) begin
      base_buf  = '0;
      base_fill = '0;
      final_d   = 1'b0;
      pad_d     = 1'b0;
      if (!coll_pad && pad_q) begin
        base_state = coll_db ? PAD_DB : PAD_AD;
      end else if (coll_final) begin
        base_state = coll_db ? IDLE : COLLECT_DB;
        if (coll_db) session_d = 1'b0;
      end else begin
        base_state = coll_db ? COLLECT_DB : COLLECT_AD;
      end
    end

    accept = bus.in_valid && bus.in_ready;
    bad    = (bus.in_nbytes > FULL_NB) ||
             ((bus.in_nbytes < FULL_NB) && !bus.in_last) ||
             ((base_state == COLLECT_DB) && !bus.in_type);
    seg_db = (base_state == IDLE) ? bus.in_type : (base_state == COLLECT_DB);

    word_ext = '0;
    for (int j = 0; j < IN_BYTES; j++) begin
      if (j < int'(bus.in_nbytes)) word_ext[8*j +: 8] = bus.in_data[8*j +: 8];
    end
    new_fill = base_fill + 5'(bus.in_nbytes);

    state_d = base_state;
    buf_d   = base_buf;
    fill_d  = base_fill;

    if (accept) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        buf_d  = base_buf | (word_ext << {base_fill, 3'b000});
        fill_d = new_fill;
        if (base_state == IDLE) session_d = 1'b1;
        if (bus.in_last) begin
          final_d = 1'b1;
          pad_d   = (new_fill == 5'd16);
          if (new_fill != 5'd16) buf_d = buf_d | (128'h1 << {new_fill, 3'b000});
          state_d = seg_db ? HOLD_DB : HOLD_AD;
        end else if (new_fill == 5'd16) begin
          state_d = seg_db ? HOLD_DB : HOLD_AD;
        end else begin
          state_d = seg_db ? COLLECT_DB : COLLECT_AD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      fill_q    <= '0;
      final_q   <= 1'b0;
      pad_q     <= 1'b0;
      session_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      final_q   <= final_d;
      pad_q     <= pad_d;
      session_q <= session_d;
      err_q     <= err_d;
    end
  end

  // start stays high for the session but drops while the final DB block is on the output.
  assign bus.blk_start    = session_q && !(pres_valid && pres_db && pres_final);
  assign bus.blk_valid_ad = pres_valid && !pres_db;
  assign bus.blk_valid_db = pres_valid && pres_db;
  assign bus.blk_data     = pres_data;
  assign bus.blk_nbytes   = pres_nbytes;
  assign err              = err_q;
endmodule

// File: tb/tb_ascon_aead128_packer.sv
// Bench for ascon_aead128_packer (IN_BYTES=4): vector table plus hand-written stall/reset/error sequences,
// expected blocks queued when words are driven and compared when the core side consumes them.
module tb_ascon_aead128_packer;
  localparam int IN_BYTES = 4;

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   nb;
    logic         db;
    logic         start;
  } blk_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nb;
    logic        typ;
    logic        last;
    logic [1:0]  nexp;
    blk_t        e0;
    blk_t        e1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic err;
  int   checks = 0;
  int   errors = 0;
  blk_t exp_q[$];
  blk_t mon_e;
  vec_t vecs[16];

  ascon_aead128_packer_if #(.IN_BYTES(IN_BYTES)) bus ();

  ascon_aead128_packer #(.IN_BYTES(IN_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic blk_t mkBlk(input logic [127:0] d, input logic [4:0] nb,
                                 input logic db, input logic st);
    blk_t b;
    b.data = d; b.nb = nb; b.db = db; b.start = st;
    return b;
  endfunction

  function automatic vec_t mkVec(input logic [31:0] d, input logic [2:0] nb, input logic typ,
                                 input logic last, input logic [1:0] nexp, input blk_t e0, input blk_t e1);
    vec_t v;
    v.data = d; v.nb = nb; v.typ = typ; v.last = last; v.nexp = nexp; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [2:0] nb, input logic typ, input logic last);
    bit ok = 1'b0;
    bus.in_data   = d;
    bus.in_nbytes = nb;
    bus.in_type   = typ;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) checkOutput("in_timeout", 128'(ok), 128'd1);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    @(posedge clk); #1;
    checkOutput("drain", 128'(exp_q.size()), 128'd0);
  endtask

  // Every block the core consumes must be the next one queued by the stimulus.
  always @(negedge clk) begin
    if (rst_n && (bus.blk_valid_ad || bus.blk_valid_db)) begin
      checkOutput("one_valid", 128'(bus.blk_valid_ad & bus.blk_valid_db), 128'd0);
      if (bus.blk_ready) begin
        checkOutput("blk_expected", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("blk_data", bus.blk_data, mon_e.data);
          checkOutput("blk_nbytes", 128'(bus.blk_nbytes), 128'(mon_e.nb));
          checkOutput("blk_is_db", 128'(bus.blk_valid_db), 128'(mon_e.db));
          checkOutput("blk_start", 128'(bus.blk_start), 128'(mon_e.start));
        end
      end
    end
  end

  initial begin
    blk_t nil, ad1, ad2, db1, dbpad, s2, ad16, adpad;
    nil   = mkBlk(128'h0, 5'd0, 1'b0, 1'b0);
    ad1   = mkBlk({4{32'h03020100}}, 5'd16, 1'b0, 1'b1);
    ad2   = mkBlk(128'h0100, 5'd1, 1'b0, 1'b1);
    db1   = mkBlk({4{32'hDDCCBBAA}}, 5'd16, 1'b1, 1'b1);
    dbpad = mkBlk(128'h1, 5'd0, 1'b1, 1'b0);
    s2    = mkBlk(128'h01CCBBAA, 5'd3, 1'b1, 1'b0);
    ad16  = mkBlk(128'h0F0E0D0C0B0A09080706050403020100, 5'd16, 1'b0, 1'b1);
    adpad = mkBlk(128'h1, 5'd0, 1'b0, 1'b1);

    vecs[0]  = mkVec(32'h03020100, 3'd4, 1'b0, 1'b0, 2'd0, nil, nil);
    vecs[1]  = mkVec(32'h03020100, 3'd4, 1'b0, 1'b0, 2'd0, nil, nil);
    vecs[2]  = mkVec(32'h03020100, 3'd4, 1'b0, 1'b0, 2'd0, nil, nil);
    vecs[3]  = mkVec(32'h03020100, 3'd4, 1'b0, 1'b0, 2'd1, ad1, nil);
    vecs[4]  = mkVec(32'h03020100, 3'd1, 1'b0, 1'b1, 2'd1, ad2, nil);
    vecs[5]  = mkVec(32'hDDCCBBAA, 3'd4, 1'b1, 1'b0, 2'd0, nil, nil);
    vecs[6]  = mkVec(32'hDDCCBBAA, 3'd4, 1'b1, 1'b0, 2'd0, nil, nil);
    vecs[7]  = mkVec(32'hDDCCBBAA, 3'd4, 1'b1, 1'b0, 2'd0, nil, nil);
    vecs[8]  = mkVec(32'hDDCCBBAA, 3'd4, 1'b1, 1'b0, 2'd1, db1, nil);
    vecs[9]  = mkVec(32'h00000000, 3'd0, 1'b1, 1'b1, 2'd1, dbpad, nil);
    vecs[10] = mkVec(32'hEECCBBAA, 3'd3, 1'b1, 1'b1, 2'd1, s2, nil);
    vecs[11] = mkVec(32'h03020100, 3'd4, 1'b0, 1'b0, 2'd0, nil, nil);
    vecs[12] = mkVec(32'h07060504, 3'd4, 1'b0, 1'b0, 2'd0, nil, nil);
    vecs[13] = mkVec(32'h0B0A0908, 3'd4, 1'b0, 1'b0, 2'd0, nil, nil);
    vecs[14] = mkVec(32'h0F0E0D0C, 3'd4, 1'b0, 1'b1, 2'd2, ad16, adpad);
    vecs[15] = mkVec(32'h00000000, 3'd0, 1'b1, 1'b1, 2'd1, dbpad, nil);

    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_nbytes = '0;
    bus.in_type   = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid_ad", 128'(bus.blk_valid_ad), 128'd0);
    checkOutput("rst_valid_db", 128'(bus.blk_valid_db), 128'd0);
    checkOutput("rst_start", 128'(bus.blk_start), 128'd0);
    checkOutput("rst_data", bus.blk_data, 128'd0);
    checkOutput("rst_nbytes", 128'(bus.blk_nbytes), 128'd0);
    checkOutput("rst_err", 128'(err), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].nexp >= 2'd1) exp_q.push_back(vecs[i].e0);
      if (vecs[i].nexp == 2'd2) exp_q.push_back(vecs[i].e1);
      applyStimulus(vecs[i].data, vecs[i].nb, vecs[i].typ, vecs[i].last);
    end
    waitDrain();

    $display("[TB] backpressure in HOLD_AD");
    bus.blk_ready = 1'b0;
    exp_q.push_back(mkBlk({4{32'hA3A2A1A0}}, 5'd16, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) applyStimulus(32'hA3A2A1A0, 3'd4, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("stall_valid_ad", 128'(bus.blk_valid_ad), 128'd1);
      checkOutput("stall_data", bus.blk_data, {4{32'hA3A2A1A0}});
      checkOutput("stall_in_ready", 128'(bus.in_ready), 128'd0);
    end
    @(posedge clk); #1;
    bus.blk_ready = 1'b1;
    exp_q.push_back(adpad);
    applyStimulus(32'h0, 3'd0, 1'b0, 1'b1);
    exp_q.push_back(dbpad);
    applyStimulus(32'h0, 3'd0, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] protocol errors");
    checkOutput("err_clear", 128'(err), 128'd0);
    exp_q.push_back(mkBlk(128'h01BBAA0D0C0B0A, 5'd6, 1'b1, 1'b0));
    applyStimulus(32'h0D0C0B0A, 3'd4, 1'b1, 1'b0);
    applyStimulus(32'hDEADBEEF, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("err_set", 128'(err), 128'd1);
    @(posedge clk); #1;
    applyStimulus(32'hFFFFFFFF, 3'd5, 1'b1, 1'b0);
    applyStimulus(32'h0000BBAA, 3'd2, 1'b1, 1'b1);
    waitDrain();
    checkOutput("err_sticky", 128'(err), 128'd1);

    $display("[TB] reset mid COLLECT_DB");
    applyStimulus(32'h55555555, 3'd4, 1'b1, 1'b0);
    applyStimulus(32'h55555555, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("session_start", 128'(bus.blk_start), 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_start", 128'(bus.blk_start), 128'd0);
    checkOutput("midrst_valid", 128'(bus.blk_valid_ad | bus.blk_valid_db), 128'd0);
    checkOutput("midrst_data", bus.blk_data, 128'd0);
    checkOutput("midrst_nbytes", 128'(bus.blk_nbytes), 128'd0);
    checkOutput("midrst_err", 128'(err), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mkBlk(128'h0144332211, 5'd4, 1'b1, 1'b0));
    applyStimulus(32'h44332211, 3'd4, 1'b1, 1'b1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
